// File: rtl/rc4_message_checker.sv
// rc4_message_checker
// Walks the decrypted-message RAM after an RC4 run and decides whether every
// byte is printable lowercase text (a-z or space). It is read-only toward the
// RAM: it issues a registered address, waits for the synchronous read data,
// and stops at the first illegal byte. The result is held in sticky pass/fail
// flags until the next accepted start.
//
// Per-byte timing (3 cycles):
//   ADDR  : msg_addr is stable; the RAM samples it on the closing edge
//   WAIT  : RAM q settles after that edge
//   CHECK : msg_rdata is judged on the closing edge
// An all-legal run of MSG_LEN bytes therefore raises done 3*MSG_LEN+1 cycles
// after the start edge. A run stopping on byte k raises it 3*(k+1)+1 cycles
// after the start edge.
//
// MSG_LEN must not exceed 2**ADDR_W. The last address is compared directly,
// so msg_addr never wraps even when MSG_LEN equals 2**ADDR_W.

module rc4_message_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] msg_addr,
    input  logic [7:0]        msg_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_index
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

    state_t state;

    // Legal message text: lowercase a-z or a space.
    function automatic logic is_legal(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    // Sequencer and registered outputs.
    // NOTE: every register in this block uses <= so that all decisions within
    // a cycle see the values from before the edge; mixing in blocking
    // assignments would make results depend on statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            msg_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_index <= '0;
        end else begin
            // done is a single-cycle pulse; only DONE raises it.
            done <= 1'b0;

            case (state)
                IDLE: begin
                    // abort is ignored here, so start wins when both are high.
                    if (start) begin
                        state      <= ADDR;
                        msg_addr   <= '0;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        fail_index <= '0;
                        busy       <= 1'b1;
                    end
                end

                ADDR: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    // abort outranks the byte decision, so an aborted run
                    // never reports pass or fail.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!is_legal(msg_rdata)) begin
                        fail       <= 1'b1;
                        fail_index <= msg_addr;
                        state      <= DONE;
                    end else if (msg_addr == LAST_ADDR) begin
                        pass  <= 1'b1;
                        state <= DONE;
                    end else begin
                        msg_addr <= msg_addr + ADDR_W'(1);
                        state    <= ADDR;
                    end
                end

                DONE: begin
                    // abort is ignored here; the completed result stands.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    // Unused encodings recover to an idle, non-busy block.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_message_checker.sv
// Testbench for rc4_message_checker.
// A synchronous-read RAM model feeds the checker. Whenever a run that should
// complete is started, a reference model scans the RAM and pushes the expected
// latency and result onto a scoreboard; the monitor pops it when done pulses.

module tb_rc4_message_checker;

    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic              abort   = 1'b0;
    logic [ADDR_W-1:0] msg_addr;
    logic [7:0]        msg_rdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic [ADDR_W-1:0] fail_index;

    rc4_message_checker #(
        .MSG_LEN(MSG_LEN),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .msg_addr  (msg_addr),
        .msg_rdata (msg_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .fail_index(fail_index)
    );

    always #5 clk = ~clk;

    // Message RAM with a registered read port.
    logic [7:0] mem [0:MSG_LEN-1];
    always @(posedge clk) msg_rdata <= mem[msg_addr];

    typedef struct {
        int                latency;
        logic              pass;
        logic              fail;
        logic [ADDR_W-1:0] idx;
    } exp_t;

    exp_t sb[$];

    int total      = 0;
    int bad        = 0;
    int cyc        = 0;
    int start_cyc  = 0;
    int done_count = 0;
    int max_addr   = 0;
    int run_id     = 0;
    int seen_run   = 0;
    int exp_done   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [7:0] b);
        return b inside {[8'h61:8'h7A], 8'h20};
    endfunction

    // Reference scan: first illegal byte stops the run after 3 cycles per byte.
    function automatic exp_t model();
        exp_t e;
        e.latency = 3 * MSG_LEN + 1;
        e.pass    = 1'b1;
        e.fail    = 1'b0;
        e.idx     = '0;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (!ref_legal(mem[i])) begin
                e.latency = 3 * (i + 1) + 1;
                e.pass    = 1'b0;
                e.fail    = 1'b1;
                e.idx     = ADDR_W'(i);
                break;
            end
        end
        return e;
    endfunction

    task automatic load_msg();
        string s;
        s = "attack at dawn";
        for (int i = 0; i < MSG_LEN; i++)
            mem[i] = (i < s.len()) ? s[i] : 8'h20;
    endtask

    // Pulse start for one cycle; returns at the negedge after the start edge.
    task automatic pulse_start(input bit expect_done);
        @(negedge clk);
        if (expect_done) begin
            sb.push_back(model());
            exp_done++;
        end
        run_id++;
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: tracks the highest address of a run and scores each done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (seen_run != run_id) begin
            seen_run = run_id;
            max_addr = 0;
        end
        if (busy === 1'b1 && int'(msg_addr) > max_addr) max_addr = int'(msg_addr);
        if (done === 1'b1) begin
            done_count++;
            check("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("done_latency", cyc - start_cyc, e.latency);
                check("done_pass", pass, e.pass);
                check("done_fail", fail, e.fail);
                check("done_fail_index", fail_index, e.idx);
                check("done_busy_low", busy, 0);
                check("pass_fail_exclusive", pass & fail, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        load_msg();

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_msg_addr", msg_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_index", fail_index, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // All-legal message
        pulse_start(1);
        check("legal_busy_start", busy, 1);
        repeat (95) @(negedge clk);
        check("legal_busy_mid", busy, 1);
        check("legal_no_early_done", done, 0);
        wait_idle("legal", 200);
        check("legal_max_addr", max_addr, 31);
        check("legal_done_count", done_count, exp_done);

        // Illegal byte 5 ('A')
        mem[5] = 8'h41;
        pulse_start(1);
        wait_idle("byte5", 200);
        check("byte5_max_addr", max_addr, 5);
        check("byte5_fail_sticky", fail, 1);
        check("byte5_index_sticky", fail_index, 5);
        check("byte5_pass_sticky", pass, 0);

        // Boundary bytes just outside the legal range at both ends
        load_msg();
        mem[0]  = 8'h7B;
        mem[31] = 8'h60;
        pulse_start(1);
        wait_idle("first_byte", 200);
        check("first_byte_index", fail_index, 0);
        mem[0] = 8'h61;
        pulse_start(1);
        wait_idle("last_byte", 200);
        check("last_byte_index", fail_index, 31);
        check("last_byte_max_addr", max_addr, 31);

        // Second start while busy is ignored
        load_msg();
        pulse_start(1);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("restart", 200);
        repeat (10) @(negedge clk);
        check("restart_done_count", done_count, exp_done);
        check("restart_max_addr", max_addr, 31);
        check("restart_pass", pass, 1);

        // Abort at cycle 20 of a run
        pulse_start(0);
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_pass", pass, 0);
        check("abort_fail", fail, 0);
        repeat (110) @(negedge clk);
        check("abort_no_done", done_count, exp_done);

        // Abort in CHECK on an illegal byte outranks the fail decision
        mem[5] = 8'h41;
        pulse_start(0);
        repeat (17) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_chk_busy", busy, 0);
        check("abort_chk_fail", fail, 0);
        check("abort_chk_index", fail_index, 0);
        repeat (30) @(negedge clk);
        check("abort_chk_no_done", done_count, exp_done);

        // Abort in IDLE is ignored; start with abort in IDLE begins the run
        load_msg();
        abort = 1'b1;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        pulse_start(1);
        abort = 1'b0;
        check("start_abort_busy", busy, 1);
        wait_idle("start_abort", 200);
        check("start_abort_pass", pass, 1);

        // Reset mid-run at address 12, start ignored during reset
        pulse_start(0);
        begin
            int n;
            n = 0;
            while (msg_addr !== ADDR_W'(12) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_mid_reached_12", msg_addr, 12);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_msg_addr", msg_addr, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_pass", pass, 0);
        check("rst_mid_fail", fail, 0);
        check("rst_mid_fail_index", fail_index, 0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_release_busy", busy, 0);
        check("rst_release_no_done", done_count, exp_done);
        pulse_start(1);
        wait_idle("rerun", 200);
        check("rerun_pass", pass, 1);
        check("rerun_fail", fail, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
